// File: rtl/hci_core_mem_target_if.sv
// HCI core port bundle: request channel from the initiator, response channel back from the target.
interface hci_core_intf #(
  parameter int unsigned DW = 32,
  parameter int unsigned UW = 1
);
  logic          req;
  logic          gnt;
  logic [31:0]   add;
  logic          wen;
  logic [DW/8-1:0] be;
  logic [DW-1:0] data;
  logic [UW-1:0] user;
  logic          r_ready;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [UW-1:0] r_user;

  modport target (
    input  req, add, wen, be, data, user, r_ready,
    output gnt, r_valid, r_data, r_user
  );

  modport initiator (
    output req, add, wen, be, data, user, r_ready,
    input  gnt, r_valid, r_data, r_user
  );
endinterface

// File: rtl/hci_core_mem_target.sv
// Register-based memory target on an HCI core port: fixed-latency response pipeline
// feeding an in-order response FIFO, with outstanding-count flow control on grants.
module hci_core_mem_target #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              enable_i,
  hci_core_intf.target                      tcdm,
  output logic                              busy_o,
  output logic [$clog2(RESP_DEPTH+1)-1:0]   outstanding_o
);

  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned OW = $clog2(BW);
  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [IW-1:0]         idx;
  logic [CW-1:0]         cnt;
  logic                  gnt;
  logic                  hs;
  logic                  pop;
  logic [DATA_WIDTH-1:0] in_d;
  logic                  push_v;
  logic [DATA_WIDTH-1:0] push_d;

  logic [DATA_WIDTH-1:0] fifo [RESP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fcnt;
  logic                  empty;

  logic                  unused_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    idx         = tcdm.add[IW+OW-1:OW];
    unused_bits = ^{tcdm.add[31:IW+OW], tcdm.add[OW-1:0], tcdm.user};
  end

  // Grant never looks at gnt itself; the count bound keeps the FIFO from overflowing.
  always_comb begin
    gnt  = rst_ni & tcdm.req & enable_i & ~clear_i & (cnt < CW'(RESP_DEPTH));
    hs   = tcdm.req & gnt;
    in_d = tcdm.wen ? mem[idx] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (hs && !tcdm.wen) begin
      for (int unsigned b = 0; b < BW; b++) begin
        if (tcdm.be[b]) mem[idx][b*8 +: 8] <= tcdm.data[b*8 +: 8];
      end
    end
  end

  // Stage 0 is the handshake cycle itself, so LATENCY-1 registers precede the FIFO push.
  if (LATENCY > 1) begin : g_pipe
    logic [LATENCY-2:0]    pv;
    logic [DATA_WIDTH-1:0] pd [LATENCY-1];

    always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
        pv <= '0;
        for (int unsigned i = 0; i < LATENCY - 1; i++) pd[i] <= '0;
      end else begin
        pv[0] <= hs;
        pd[0] <= in_d;
        for (int unsigned i = 1; i < LATENCY - 1; i++) begin
          pv[i] <= pv[i-1];
          pd[i] <= pd[i-1];
        end
      end
    end

    always_comb begin
      push_v = pv[LATENCY-2];
      push_d = pd[LATENCY-2];
    end
  end else begin : g_nopipe
    always_comb begin
      push_v = hs;
      push_d = in_d;
    end
  end

  always_comb begin
    empty = (fcnt == '0);
    pop   = ~empty & tcdm.r_ready;
  end

  always_ff @(posedge clk_i) begin
    if (push_v) fifo[wr_ptr] <= push_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push_v) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({push_v, pop})
        2'b10:   fcnt <= fcnt + CW'(1);
        2'b01:   fcnt <= fcnt - CW'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      cnt <= '0;
    end else begin
      case ({hs, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    tcdm.gnt      = gnt;
    tcdm.r_valid  = ~empty;
    tcdm.r_data   = empty ? '0 : fifo[rd_ptr];
    tcdm.r_user   = '0;
    busy_o        = (cnt != '0);
    outstanding_o = cnt;
  end

endmodule

// File: tb/tb_hci_core_mem_target.sv
// Bench for hci_core_mem_target: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based transaction model.
module tb_hci_core_mem_target;

  localparam int unsigned L = 2;
  localparam int unsigned D = 4;
  localparam int unsigned W = 16;

  typedef struct {
    logic [31:0] d;
    int unsigned rdy;
  } resp_t;

  typedef struct {
    logic        req;
    logic        wen;
    logic [31:0] add;
    logic [3:0]  be;
    logic [31:0] data;
    logic        rdy;
    logic        eg;
    logic        ev;
    logic [31:0] ed;
    int unsigned eo;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, clr, en;
  logic       busy;
  logic [2:0] outst;

  hci_core_intf #(.DW(32), .UW(1)) tcdm ();

  hci_core_mem_target #(
    .DATA_WIDTH(32),
    .MEM_WORDS (W),
    .LATENCY   (L),
    .RESP_DEPTH(D)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clr),
    .enable_i     (en),
    .tcdm         (tcdm),
    .busy_o       (busy),
    .outstanding_o(outst)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          mvalid = 0;

  logic [31:0] rmem [W];
  resp_t       q[$];
  int unsigned cnt = 0;

  logic        d_req, d_wen, d_rdy, d_en, d_clr, d_rst;
  logic [31:0] d_add, d_data;
  logic [3:0]  d_be;
  logic        o_gnt, o_rv, o_busy;
  logic [31:0] o_rd;
  logic [2:0]  o_out;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    logic        eg, ev;
    logic [31:0] ed;
    int unsigned w;
    resp_t       r;
    @(posedge clk);
    #1;
    tcdm.req = d_req; tcdm.wen = d_wen; tcdm.add = d_add; tcdm.be = d_be;
    tcdm.data = d_data; tcdm.r_ready = d_rdy; tcdm.user = 1'b0;
    en = d_en; clr = d_clr; rst_n = d_rst;
    @(negedge clk);
    o_gnt = tcdm.gnt; o_rv = tcdm.r_valid; o_rd = tcdm.r_data;
    o_out = outst; o_busy = busy;
    eg = d_rst & d_req & d_en & ~d_clr & (cnt < D);
    ev = (q.size() > 0) && (q[0].rdy <= cyc);
    ed = ev ? q[0].d : 32'h0;
    if (mvalid) begin
      chk("gnt", {31'h0, o_gnt}, {31'h0, eg});
      chk("r_valid", {31'h0, o_rv}, {31'h0, ev});
      chk("r_data", o_rd, ed);
      chk("outstanding", {29'h0, o_out}, cnt);
      chk("busy", {31'h0, o_busy}, {31'h0, cnt != 0});
      chk("r_user", {31'h0, tcdm.r_user}, 32'h0);
    end
    if (!d_rst) begin
      q.delete();
      cnt = 0;
      for (int i = 0; i < W; i++) rmem[i] = 32'h0;
      mvalid = 1;
    end else if (d_clr) begin
      q.delete();
      cnt = 0;
    end else begin
      if (ev && d_rdy) begin
        q.delete(0);
        cnt--;
      end
      if (eg) begin
        w = (d_add >> 2) % W;
        r.rdy = cyc + L;
        if (d_wen) r.d = rmem[w];
        else begin
          r.d = 32'h0;
          for (int b = 0; b < 4; b++) if (d_be[b]) rmem[w][8*b +: 8] = d_data[8*b +: 8];
        end
        q.push_back(r);
        cnt++;
      end
    end
    cyc++;
  endtask

  task automatic idle();
    d_req = 1'b0;
  endtask

  task automatic set_rd(input logic [31:0] a);
    d_req = 1'b1; d_wen = 1'b1; d_add = a; d_be = 4'h0; d_data = 32'h0;
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [31:0] dt, input logic [3:0] be);
    d_req = 1'b1; d_wen = 1'b0; d_add = a; d_be = be; d_data = dt;
  endtask

  task automatic idle_n(input int n);
    idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int grants, got, nxt, seen;

    tbl[0]  = '{1'b1, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0, 0};
    tbl[1]  = '{1'b1, 1'b1, 32'h10, 4'h0, 32'h0,       1'b1, 1'b1, 1'b0, 32'h0, 1};
    tbl[2]  = '{1'b0, 1'b1, 32'h0,  4'h0, 32'h0,       1'b1, 1'b0, 1'b1, 32'h0, 2};
    tbl[3]  = '{1'b0, 1'b1, 32'h0,  4'h0, 32'h0,       1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1};
    tbl[4]  = '{1'b0, 1'b1, 32'h0,  4'h0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0, 0};
    tbl[5]  = '{1'b1, 1'b0, 32'h20, 4'hF, 32'h11223344, 1'b1, 1'b1, 1'b0, 32'h0, 0};
    tbl[6]  = '{1'b1, 1'b0, 32'h20, 4'h2, 32'h0000AB00, 1'b1, 1'b1, 1'b0, 32'h0, 1};
    tbl[7]  = '{1'b1, 1'b1, 32'h20, 4'h0, 32'h0,       1'b1, 1'b1, 1'b1, 32'h0, 2};
    tbl[8]  = '{1'b0, 1'b1, 32'h0,  4'h0, 32'h0,       1'b1, 1'b0, 1'b1, 32'h0, 2};
    tbl[9]  = '{1'b0, 1'b1, 32'h0,  4'h0, 32'h0,       1'b1, 1'b0, 1'b1, 32'h1122AB44, 1};
    tbl[10] = '{1'b0, 1'b1, 32'h0,  4'h0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0, 0};
    tbl[11] = '{1'b1, 1'b1, 32'h53, 4'h0, 32'h0,       1'b1, 1'b1, 1'b0, 32'h0, 0};
    tbl[12] = '{1'b0, 1'b1, 32'h0,  4'h0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0, 1};
    tbl[13] = '{1'b0, 1'b1, 32'h0,  4'h0, 32'h0,       1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1};
    tbl[14] = '{1'b0, 1'b1, 32'h0,  4'h0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0, 0};

    tcdm.req = 0; tcdm.wen = 0; tcdm.add = 0; tcdm.be = 0; tcdm.data = 0;
    tcdm.user = 0; tcdm.r_ready = 0; rst_n = 0; clr = 0; en = 0;
    d_req = 0; d_wen = 0; d_add = 0; d_be = 0; d_data = 0;
    d_rdy = 1; d_en = 1; d_clr = 0; d_rst = 0;

    cycle();
    cycle();
    d_rst = 1;
    chk("reset_rvalid", {31'h0, o_rv}, 32'h0);
    chk("reset_out", {29'h0, o_out}, 32'h0);
    idle_n(2);

    // directed table: write/read latency, byte enables, address aliasing
    for (int i = 0; i < 15; i++) begin
      d_req = tbl[i].req; d_wen = tbl[i].wen; d_add = tbl[i].add; d_be = tbl[i].be;
      d_data = tbl[i].data; d_rdy = tbl[i].rdy; d_en = 1; d_clr = 0; d_rst = 1;
      cycle();
      chk($sformatf("vec%0d_gnt", i), {31'h0, o_gnt}, {31'h0, tbl[i].eg});
      chk($sformatf("vec%0d_rvalid", i), {31'h0, o_rv}, {31'h0, tbl[i].ev});
      chk($sformatf("vec%0d_rdata", i), o_rd, tbl[i].ed);
      chk($sformatf("vec%0d_out", i), {29'h0, o_out}, tbl[i].eo);
    end

    // backpressure: fill with r_ready low, then drain in order
    for (int i = 0; i < 8; i++) begin
      set_wr(i * 4, 32'hA5000000 | i, 4'hF);
      cycle();
    end
    idle_n(5);
    d_rdy = 0; grants = 0; nxt = 0;
    for (int k = 0; k < 10; k++) begin
      set_rd(nxt * 4);
      cycle();
      if (o_gnt) begin grants++; nxt++; end
    end
    chk("bp_grants", grants, 4);
    chk("bp_gnt_low", {31'h0, o_gnt}, 32'h0);
    chk("bp_out_full", {29'h0, o_out}, 32'd4);
    d_rdy = 1; got = 0;
    for (int k = 0; k < 60 && (got < 8 || nxt < 8); k++) begin
      if (nxt < 8) set_rd(nxt * 4); else idle();
      cycle();
      if (o_rv) begin
        chk("bp_order", o_rd, 32'hA5000000 | got);
        got++;
      end
      if (o_gnt) nxt++;
    end
    chk("bp_count", got, 8);
    idle_n(4);

    // simultaneous handshake and pop at outstanding == 3
    d_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      set_rd(k * 4);
      cycle();
    end
    idle_n(2);
    chk("sim_pre_out", {29'h0, o_out}, 32'd3);
    d_rdy = 1;
    for (int k = 0; k < 5; k++) begin
      set_rd(k * 4);
      cycle();
      chk("sim_out_hold", {29'h0, o_out}, 32'd3);
    end
    idle_n(6);

    // clear mid-stream; the write presented during the clear is discarded
    set_wr(32'h28, 32'hCAFEF00D, 4'hF);
    cycle();
    idle_n(4);
    d_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      set_rd(32'h28);
      cycle();
    end
    set_wr(32'h28, 32'h0BADBAD0, 4'hF);
    d_clr = 1;
    cycle();
    d_clr = 0;
    d_rdy = 1;
    idle_n(1);
    chk("clr_rvalid", {31'h0, o_rv}, 32'h0);
    chk("clr_out", {29'h0, o_out}, 32'h0);
    chk("clr_busy", {31'h0, o_busy}, 32'h0);
    set_rd(32'h28);
    cycle();
    idle();
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (o_rv) begin
        chk("clr_mem", o_rd, 32'hCAFEF00D);
        seen++;
      end
    end
    chk("clr_resp_count", seen, 1);

    // reset mid-operation clears memory and all in-flight state
    set_wr(32'h30, 32'h12345678, 4'hF);
    cycle();
    d_rdy = 0;
    set_rd(32'h30);
    cycle();
    cycle();
    set_wr(32'h30, 32'h77777777, 4'hF);
    d_rst = 0;
    cycle();
    chk("rst_gnt", {31'h0, o_gnt}, 32'h0);
    d_rst = 1;
    d_rdy = 1;
    idle_n(1);
    chk("rst_rvalid", {31'h0, o_rv}, 32'h0);
    chk("rst_rdata", o_rd, 32'h0);
    chk("rst_busy", {31'h0, o_busy}, 32'h0);
    chk("rst_out", {29'h0, o_out}, 32'h0);
    set_rd(32'h30);
    cycle();
    idle();
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (o_rv) begin
        chk("rst_mem", o_rd, 32'h0);
        seen++;
      end
    end
    chk("rst_resp_count", seen, 1);

    // randomized traffic against the transaction model
    for (int k = 0; k < 3000; k++) begin
      d_req  = ($urandom % 4) != 0;
      d_wen  = $urandom % 2;
      d_add  = $urandom;
      d_be   = 4'($urandom);
      d_data = $urandom;
      d_rdy  = ($urandom % 4) != 0;
      d_en   = ($urandom % 8) != 0;
      d_clr  = ($urandom % 64) == 0;
      d_rst  = ($urandom % 500) != 0;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
